// File: rtl/interrupt_requester_if.sv
// interrupt_requester_if: req/ack/id handshake between an interrupt source and the controller.
interface interrupt_requester_if;
    logic       interrupt_req;
    logic       interrupt_ack;
    logic [7:0] interrupt_id;
    modport master (output interrupt_req, output interrupt_id, input interrupt_ack);
    modport slave  (input interrupt_req, input interrupt_id, output interrupt_ack);
endinterface

// File: rtl/interrupt_requester.sv
// interrupt_requester: latches event pulses as pending and issues one interrupt request at a time.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the lowest unmasked pending index wins.
module interrupt_requester #(
    parameter int NUM_SRC     = 8,
    parameter int ID_BASE     = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_SRC-1:0]    event_in,
    input  logic [NUM_SRC-1:0]    event_mask,
    interrupt_requester_if.master irq,
    output logic [NUM_SRC-1:0]    pending,
    output logic                  busy,
    output logic                  timeout_err,
    input  logic                  err_clr
);
    localparam int IW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t             state;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      win_idx;
    logic               win_vld;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_SRC-1:0] cand;
    logic [NUM_SRC-1:0] ack_clr;
    logic               acked;
    logic               req;
    logic [7:0]         id;

    assign cand              = pending & event_mask;
    assign acked             = state == REQ && irq.interrupt_ack;
    assign ack_clr           = acked ? NUM_SRC'(1) << idx : '0;
    assign cnt_nxt           = cnt + CW'(1);
    assign busy              = state != IDLE;
    assign irq.interrupt_req = req;
    assign irq.interrupt_id  = id;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr;

    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_SRC; k++)
            if (!win_vld && cand[(int'(rr_ptr) + k) % NUM_SRC]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(rr_ptr) + k) % NUM_SRC);
            end
    end
`else
    always_comb begin
        win_vld = |cand;
        win_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--)
            if (cand[k]) win_idx = IW'(k);
    end
`endif

    // GAP arbitrates like IDLE so back-to-back requests are spaced by a single low cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            idx         <= '0;
            cnt         <= '0;
            req         <= 1'b0;
            id          <= '0;
            timeout_err <= 1'b0;
`ifdef ROUND_ROBIN_EN
            rr_ptr      <= '0;
`endif
        end else begin
            pending <= (pending & ~ack_clr) | event_in;
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                REQ: begin
                    if (irq.interrupt_ack) begin
                        req   <= 1'b0;
                        state <= GAP;
`ifdef ROUND_ROBIN_EN
                        rr_ptr <= idx == IW'(NUM_SRC - 1) ? '0 : idx + IW'(1);
`endif
                    end else if (cnt_nxt == CW'(ACK_TIMEOUT)) begin
                        req         <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= GAP;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: begin
                    if (win_vld) begin
                        state <= REQ;
                        idx   <= win_idx;
                        id    <= 8'(ID_BASE) + 8'(win_idx);
                        cnt   <= '0;
                        req   <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
